// File: rtl/pfx_add_arbiter.sv
// pfx_add_arbiter: shares one external WIDTH-bit prefix adder between
// NREQ requesters; E stage drives the adder, R stage returns the result.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   req_valid/req_ready per-requester handshake (one-hot grant)
//   req_a/req_b/req_cin packed operands, slot i at [i*WIDTH +: WIDTH]
//   add_a/add_b/add_cin registered operands to the adder
//   add_sum/add_cout    adder result, combinational from add_*
//   rsp_valid/rsp_ready result handshake
//   rsp_id/rsp_sum/rsp_cout result owner, sum, carry-out
//
// Build option: define PFX_ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins).

module pfx_add_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
);

  logic            e_valid;
  logic [IDW-1:0]  e_id;
  logic            r_valid;
  logic [IDW-1:0]  r_id;
  logic [WIDTH-1:0] r_sum;
  logic            r_cout;

  logic            r_free;
  logic            e_free;
  logic            e_move;
  logic            xfer;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;

  assign r_free = !r_valid || rsp_ready;
  assign e_free = !e_valid || r_free;
  assign e_move = e_valid && r_free;

  // Grant only ever marks a valid requester, so a grant with a
  // free E stage is a transfer.  Gated by rst so req_ready is 0
  // while reset is held, even with requests pending.
  assign req_ready = rst ? '0 : (gnt & {NREQ{e_free}});
  assign xfer      = !rst && gnt_any && e_free;

`ifdef PFX_ARB_RR_EN

  // ptr is the highest-priority index for the next grant.
  logic [IDW-1:0] ptr;

  always_comb begin
    int j;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req_valid[j]) begin
        gnt[j]  = 1'b1;
        gnt_id  = IDW'(j);
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      if (gnt_id == IDW'(NREQ - 1))
        ptr <= '0;
      else
        ptr <= gnt_id + 1'b1;
    end
  end

`else

  // Descending scan so the lowest valid index is the last writer.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_id  = IDW'(j);
        gnt_any = 1'b1;
      end
    end
  end

`endif

  // E stage: operand registers feed the adder directly.  They are
  // only written on a transfer, so they keep the last operands
  // when E drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid <= 1'b0;
      e_id    <= '0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      if (xfer) begin
        e_valid <= 1'b1;
        e_id    <= gnt_id;
        add_a   <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
        add_b   <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
        add_cin <= req_cin[gnt_id];
      end else if (e_move) begin
        e_valid <= 1'b0;
      end
    end
  end

  // R stage: captures the adder result; holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      if (e_move) begin
        r_valid <= 1'b1;
        r_id    <= e_id;
        r_sum   <= add_sum;
        r_cout  <= add_cout;
      end else if (rsp_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;

endmodule

// File: tb/tb_pfx_add_arbiter.sv
// tb_pfx_add_arbiter: scoreboard bench for pfx_add_arbiter with a
// behavioural adder; directed vectors with hand-computed sums.

module tb_pfx_add_arbiter;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_cin;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  pfx_add_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the prefix adder.
  assign {add_cout, add_sum} =
    {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  sum;
    logic          cout;
  } exp_t;

  exp_t         sb[$];
  int           glog[$];
  int           rlog[$];
  logic [W-1:0] ex_sum [N];
  logic         ex_cout [N];
  int           tb_ptr = 0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pick(logic [N-1:0] v, int p);
    logic [N-1:0] g = '0;
    bit           f = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (!f && v[j]) begin
        g[j] = 1'b1;
        f    = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic int oh2i(logic [N-1:0] g);
    int r = 0;
    for (int k = 0; k < N; k++)
      if (g[k]) r = k;
    return r;
  endfunction

  // Monitor: pops on response handshakes, pushes on transfers.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    exp_t         e;
    exp_t         n;
    int           gi;
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        rlog.push_back(int'(rsp_id));
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_rsp: got id %0d sum %0h, want none",
                   rsp_id, rsp_sum);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_sum", rsp_sum, e.sum);
          chk("rsp_cout", rsp_cout, e.cout);
        end
      end
      eg = pick(req_valid, tb_ptr);
      if (req_ready != '0)
        chk("grant", req_ready, eg);
      if ((req_valid & req_ready) != '0) begin
        gi     = oh2i(eg);
        n.id   = IW'(gi);
        n.sum  = ex_sum[gi];
        n.cout = ex_cout[gi];
        glog.push_back(gi);
        sb.push_back(n);
`ifdef PFX_ARB_RR_EN
        tb_ptr = (gi + 1) % N;
`endif
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic setop(int i, logic [W-1:0] a, logic [W-1:0] b,
                       logic c, logic [W-1:0] s, logic co);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
    ex_sum[i]       = s;
    ex_cout[i]      = co;
  endtask

  task automatic do_reset(logic [N-1:0] v);
    rst       = 1'b1;
    req_valid = v;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    sb.delete();
    tb_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      cyc1();
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    cyc1();
    cyc1();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int exp3 [5];
    int exp4 [5];
    int e6;
    int cnt1;
    logic [IW-1:0] s_id;
    logic [W-1:0]  s_sum;
    logic          s_cout;
`ifdef PFX_ARB_RR_EN
    exp3 = '{0, 1, 2, 3, 0};
    exp4 = '{1, 0, 1, 0, 1};
    e6   = 3;
`else
    exp3 = '{0, 0, 0, 0, 0};
    exp4 = '{0, 0, 0, 0, 0};
    e6   = 0;
`endif
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      ex_sum[i]  = '0;
      ex_cout[i] = 1'b0;
    end
    #2;
    do_reset('1);

    // 1: all-ones + 1 wraps to 0 with carry out, one-cycle latency
    setop(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    cyc1();
    req_valid = '0;
    chk("t1_lat_early", rsp_valid, 0);
    cyc1();
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_sum", rsp_sum, 0);
    chk("t1_cout", rsp_cout, 1);
    chk("t1_hold_a", add_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_hold_b", add_b, 64'h1);
    drain();

    // 2: carry-in into the sign bit
    setop(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1,
          64'h8000_0000_0000_0000, 1'b0);
    req_valid = 4'b0100;
    cyc1();
    req_valid = '0;
    cyc1();
    chk("t2_valid", rsp_valid, 1);
    chk("t2_id", rsp_id, 2);
    chk("t2_sum", rsp_sum, 64'h8000_0000_0000_0000);
    chk("t2_cout", rsp_cout, 0);
    drain();

    // 3: all requesters pending, full throughput
    do_reset('1);
    setop(0, 64'h1, 64'h2, 1'b0, 64'h3, 1'b0);
    setop(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          1'b1, 64'h1, 1'b1);
    setop(2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
          1'b0, 64'h2222_2222_2222_2211, 1'b0);
    setop(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    glog.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 1; k <= 5; k++) begin
      cyc1();
      if (k >= 2) chk("t3_b2b", rsp_valid, 1);
    end
    req_valid = '0;
    cyc1();
    chk("t3_b2b_last", rsp_valid, 1);
    drain();
    chk("t3_ngrant", glog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) chk("t3_order", glog[i], exp3[i]);

    // 4: backpressure for 5 cycles
    glog.delete();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    s_id   = '0;
    s_sum  = '0;
    s_cout = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc1();
      if (k >= 2) chk("t4_stall_ready", req_ready, 0);
      if (k == 2) begin
        s_id   = rsp_id;
        s_sum  = rsp_sum;
        s_cout = rsp_cout;
        chk("t4_stall_valid", rsp_valid, 1);
        chk("t4_hold_id", s_id, exp4[0]);
      end
      if (k >= 3) begin
        chk("t4_stable_id", rsp_id, s_id);
        chk("t4_stable_sum", rsp_sum, s_sum);
        chk("t4_stable_cout", rsp_cout, s_cout);
      end
    end
    rsp_ready = 1'b1;
    repeat (3) cyc1();
    req_valid = '0;
    drain();
    chk("t4_ngrant", glog.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < glog.size()) chk("t4_order", glog[i], exp4[i]);

    // 5: reset with E and R both full
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    cyc1();
    cyc1();
    chk("t5_full", rsp_valid, 1);
    do_reset(4'b0100);
    glog.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    cyc1();
    req_valid = '0;
    chk("t5_ngrant", glog.size(), 1);
    if (glog.size() > 0) chk("t5_first", glog[0], 0);
    drain();

    // 6: req1 withdraws while blocked
    glog.delete();
    rlog.delete();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    cyc1();
    cyc1();
    req_valid = 4'b0010;
    cyc1();
    chk("t6_blocked", req_ready, 0);
    cyc1();
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    glog.delete();
    req_valid = 4'b1001;
    cyc1();
    req_valid = '0;
    chk("t6_ngrant", glog.size(), 1);
    if (glog.size() > 0) chk("t6_next", glog[0], e6);
    drain();
    cnt1 = 0;
    foreach (rlog[i]) if (rlog[i] == 1) cnt1++;
    chk("t6_no_id1", cnt1, 0);
    chk("t6_nrsp", rlog.size(), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
